// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// fixed settle window before the result and flags are captured and returned.
module alu_share_arbiter #(
  parameter int WIDTH         = 32,
  parameter int SHAMT_W       = 5,
  parameter int CTRL_W        = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*WIDTH-1:0]   req_op1,
  input  logic [2*WIDTH-1:0]   req_op2,
  input  logic [2*SHAMT_W-1:0] req_shamt,
  input  logic [2*CTRL_W-1:0]  req_ctrl,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH-1:0]     rsp_result,
  output logic [2:0]           rsp_flags,
  output logic [WIDTH-1:0]     alu_in1,
  output logic [WIDTH-1:0]     alu_in2,
  output logic [SHAMT_W-1:0]   alu_shamt,
  output logic [CTRL_W-1:0]    alu_ctrl,
  input  logic [WIDTH-1:0]     alu_out,
  input  logic                 alu_neg,
  input  logic                 alu_zero,
  input  logic                 alu_carry,
  output logic                 busy
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic [SHAMT_W-1:0] shamt;
    logic [CTRL_W-1:0]  ctrl;
  } op_t;

  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

  op_t        req_op [2];
  op_t        issued;
  state_t     state;
  logic       last_grant;
  logic [CNT_W-1:0] cnt;
  logic [1:0] win;
  logic       win_id;

  for (genvar i = 0; i < 2; i++) begin : g_req
    assign req_op[i] = {req_op1[i*WIDTH +: WIDTH], req_op2[i*WIDTH +: WIDTH],
                        req_shamt[i*SHAMT_W +: SHAMT_W], req_ctrl[i*CTRL_W +: CTRL_W]};
  end

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    win = req_valid;
    if (req_valid == 2'b11) win = last_grant ? 2'b01 : 2'b10;
  end

  assign win_id    = win[1];
  assign req_ready = (rst_n && state == IDLE) ? win : 2'b00;
  assign busy      = (state != IDLE);

  assign alu_in1   = issued.op1;
  assign alu_in2   = issued.op2;
  assign alu_shamt = issued.shamt;
  assign alu_ctrl  = issued.ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= 3'b000;
      issued     <= '0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|(req_valid & req_ready)) begin
            issued     <= req_op[win_id];
            rsp_id     <= win_id;
            last_grant <= win_id;
            cnt        <= CNT_W'(SETTLE_CYCLES - 1);
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result <= alu_out;
            rsp_flags  <= {alu_neg, alu_zero, alu_carry};
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
